// File: rtl/cop_mem_txn_seq_if.sv
// Bundle request, memory port and bundle response signals of the
// coprocessor memory transaction sequencer, grouped as one interface.
// The slave view is the sequencer; the master view is its environment
// (execute stage issuing bundles plus the memory slave answering them).
interface cop_mem_txn_seq_if;
  // Bundle request from the execute stage
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_count;
  logic [3:0]   req_wen;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_ben;

  // Single memory port
  logic         mem_cen;
  logic         mem_wen;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_ben;
  logic         mem_stall;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rdata;
  logic         mem_error;

  // Bundle completion towards writeback
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic [3:0]   rsp_error;
  logic [3:0]   rsp_done;

  modport slave (
    input  req_valid, req_count, req_wen, req_addr, req_wdata, req_ben,
    input  mem_stall, mem_rsp_valid, mem_rdata, mem_error,
    output req_ready,
    output mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben,
    output rsp_valid, rsp_rdata, rsp_error, rsp_done
  );

  modport master (
    output req_valid, req_count, req_wen, req_addr, req_wdata, req_ben,
    output mem_stall, mem_rsp_valid, mem_rdata, mem_error,
    input  req_ready,
    input  mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben,
    input  rsp_valid, rsp_rdata, rsp_error, rsp_done
  );
endinterface

// File: rtl/cop_mem_txn_seq.sv
// Coprocessor memory transaction sequencer.
// Takes a bundle of up to NTXN memory transactions, issues them one at a
// time in index order over a single memory port, gathers read data and
// error status per transaction and pulses rsp_valid once per bundle.
// The first failing transaction (error response or timeout) aborts the
// rest of the bundle.
module cop_mem_txn_seq #(
  parameter int NTXN    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               g_clk,
  input  logic               g_reset,
  cop_mem_txn_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_VAL   = 8'(TIMEOUT);
  localparam logic [2:0] NTXN_VAL  = 3'(NTXN);

  state_t       state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   timer_q, timer_d;
  logic [2:0]   count_q, count_d;
  logic [3:0]   wen_q, wen_d;
  logic [127:0] addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [15:0]  ben_q, ben_d;
  logic [127:0] rdata_q, rdata_d;
  logic [3:0]   error_q, error_d;
  logic [3:0]   done_q, done_d;

  logic [2:0]   count_clamped;
  logic         last_txn;
  logic         issuing;

  // Per-transaction views of the latched bundle
  logic [31:0]  addr_w  [NTXN];
  logic [31:0]  wdata_w [NTXN];
  logic [3:0]   ben_w   [NTXN];

  for (genvar gi = 0; gi < NTXN; gi++) begin : g_txn_view
    assign addr_w[gi]  = addr_q[32*gi +: 32];
    assign wdata_w[gi] = wdata_q[32*gi +: 32];
    assign ben_w[gi]   = ben_q[4*gi +: 4];
  end

  assign count_clamped = (bus.req_count > NTXN_VAL) ? NTXN_VAL : bus.req_count;
  assign last_txn      = ({1'b0, idx_q} == (count_q - 3'd1));
  assign issuing       = (state_q == ISSUE);

  // Memory port is driven only in ISSUE, straight from the latched fields,
  // so it stays stable for as long as the slave stalls.
  assign bus.mem_cen   = issuing;
  assign bus.mem_wen   = issuing & wen_q[idx_q];
  assign bus.mem_addr  = issuing ? addr_w[idx_q]  : 32'd0;
  assign bus.mem_wdata = issuing ? wdata_w[idx_q] : 32'd0;
  assign bus.mem_ben   = issuing ? ben_w[idx_q]   : 4'd0;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;
  assign bus.rsp_done  = done_q;

  // Next-state and result collection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    count_d = count_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    rdata_d = rdata_q;
    error_d = error_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          count_d = count_clamped;
          wen_d   = bus.req_wen;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          ben_d   = bus.req_ben;
          rdata_d = '0;
          error_d = '0;
          done_d  = '0;
          idx_d   = 2'd0;
          timer_d = 8'd0;
          state_d = (count_clamped == 3'd0) ? DONE : ISSUE;
        end
      end

      ISSUE: begin
        if (!bus.mem_stall) begin
          timer_d = 8'd0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A response on the final timer cycle still counts as a response.
        if (bus.mem_rsp_valid) begin
          done_d[idx_q]  = 1'b1;
          error_d[idx_q] = bus.mem_error;
          if (!wen_q[idx_q] && !bus.mem_error) begin
            rdata_d[{idx_q, 5'b0} +: 32] = bus.mem_rdata;
          end
          if (bus.mem_error || last_txn) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end else if (timer_q == TMO_VAL) begin
          done_d[idx_q]  = 1'b1;
          error_d[idx_q] = 1'b1;
          state_d        = DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bundle registers
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      timer_q <= 8'd0;
      count_q <= 3'd0;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      rdata_q <= '0;
      error_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cop_mem_txn_seq.sv
// Testbench for cop_mem_txn_seq: directed and random bundles, a memory
// responder acting from per-transaction plans, and a scoreboard that
// compares each completed bundle against results derived from the plans.
module tb_cop_mem_txn_seq;
  localparam int TMO = 8;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    int          stall;
    int          delay;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [127:0] rdata;
    logic [3:0]   err;
    logic [3:0]   done;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cop_mem_txn_seq_if bus ();

  cop_mem_txn_seq #(.NTXN(4), .TIMEOUT(TMO)) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .bus     (bus.slave)
  );

  logic        r_valid = 1'b0;
  logic        m_valid = 1'b0;
  logic        r_err   = 1'b0;
  logic        r_stall = 1'b0;
  logic [31:0] r_data  = 32'd0;
  logic        hold    = 1'b0;

  assign bus.mem_rsp_valid = r_valid | m_valid;
  assign bus.mem_error     = r_err;
  assign bus.mem_rdata     = r_data;
  assign bus.mem_stall     = r_stall;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  plan_t pl[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave: follows the plan of each issued transaction
  initial begin : responder
    int    mode;
    int    wcnt;
    plan_t cur;
    mode = 0;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      r_valid = 1'b0;
      r_err   = 1'b0;
      r_stall = 1'b0;
      r_data  = $urandom;
      if (rst || hold) begin
        mode = 0;
      end else begin
        if (mode == 0 && bus.mem_cen) begin
          if (plan_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue got addr=%h want no request", bus.mem_addr);
          end else begin
            cur  = plan_q.pop_front();
            mode = 2;
          end
        end
        if (mode == 0) begin
          // stray responses outside WAIT must be ignored
          r_valid = ($urandom_range(0, 7) == 0);
          r_err   = 1'($urandom);
        end else if (mode == 2) begin
          chk("issue_fields", {bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_ben},
              {1'b1, cur.wen, cur.addr, cur.wdata, cur.ben});
          r_valid = ($urandom_range(0, 7) == 0);
          r_err   = 1'($urandom);
          if (cur.stall > 0) begin
            r_stall   = 1'b1;
            cur.stall = cur.stall - 1;
          end else begin
            mode = 1;
            wcnt = 0;
          end
        end else begin
          chk("wait_bus_idle", {bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_ben}, '0);
          if (wcnt == cur.delay) begin
            r_valid = 1'b1;
            r_err   = cur.err;
            r_data  = cur.rdata;
            mode    = 0;
          end else begin
            r_err = 1'($urandom);
            if (wcnt == TMO) mode = 0;
            else wcnt++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: one check set per completed bundle
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_rsp got rsp_valid=1 want 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          $display("bundle cyc=%0d done=%b err=%b rdata=%h", cyc, bus.rsp_done, bus.rsp_error, bus.rsp_rdata);
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_done", bus.rsp_done, e.done);
          chk("rsp_error", bus.rsp_error, e.err);
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic default_plan();
    for (int i = 0; i < 4; i++) begin
      pl[i].stall = 0;
      pl[i].delay = 0;
      pl[i].err   = 1'b0;
      pl[i].rdata = $urandom;
    end
  endtask

  task automatic rand_plan();
    int r;
    for (int i = 0; i < 4; i++) begin
      pl[i].stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      r = $urandom_range(0, 19);
      if (r < 14)      pl[i].delay = $urandom_range(0, 2);
      else if (r < 18) pl[i].delay = $urandom_range(3, TMO);
      else             pl[i].delay = $urandom_range(TMO + 1, TMO + 4);
      pl[i].err   = ($urandom_range(0, 9) == 0);
      pl[i].rdata = $urandom;
    end
  endtask

  // Issue one bundle and derive its expected outcome from the plans
  task automatic send(input logic [2:0] cnt, input logic [3:0] wen, input logic [127:0] addr,
                      input logic [127:0] wdata, input logic [15:0] ben);
    exp_t e;
    int   n;
    int   t;
    bit   stop;
    int   guard;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.req_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL req_ready_wait got ready=%b want 1", bus.req_ready);
    end else begin
      bus.req_valid = 1'b1;
      bus.req_count = cnt;
      bus.req_wen   = wen;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_ben   = ben;
      n = (cnt > 3'd4) ? 4 : int'(cnt);
      e.rdata = '0;
      e.err   = '0;
      e.done  = '0;
      t    = cyc + 1;
      stop = 1'b0;
      for (int i = 0; i < n && !stop; i++) begin
        plan_t p;
        p       = pl[i];
        p.wen   = wen[i];
        p.addr  = addr[32*i +: 32];
        p.wdata = wdata[32*i +: 32];
        p.ben   = ben[4*i +: 4];
        plan_q.push_back(p);
        t = t + 1 + p.stall;
        e.done[i] = 1'b1;
        if (p.delay > TMO) begin
          t = t + TMO + 1;
          e.err[i] = 1'b1;
          stop = 1'b1;
        end else begin
          t = t + p.delay + 1;
          e.err[i] = p.err;
          if (!p.wen && !p.err) e.rdata[32*i +: 32] = p.rdata;
          if (p.err) stop = 1'b1;
        end
      end
      e.cyc = t;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : stimulus
    logic [127:0] a;
    logic [127:0] wd;
    int           guard;
    bus.req_valid = 1'b0;
    bus.req_count = 3'd0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_ben   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem", {bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_ben}, '0);
    chk("reset_rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_done}, '0);
    chk("reset_rdata", bus.rsp_rdata, '0);
    chk("reset_ready", bus.req_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // four reads, rdata = addr ^ A5A5A5A5
    default_plan();
    a = {32'h10C, 32'h108, 32'h104, 32'h100};
    for (int i = 0; i < 4; i++) pl[i].rdata = a[32*i +: 32] ^ 32'hA5A5A5A5;
    send(3'd4, 4'b0000, a, rnd128(), 16'hFFFF);

    // write with stall then read
    default_plan();
    pl[0].stall = 3;
    wd = rnd128();
    wd[31:0] = 32'hDEADBEEF;
    send(3'd2, 4'b0001, {64'h0, 32'h204, 32'h200}, wd, 16'h00F3);

    // error on txn1 aborts txn2
    default_plan();
    pl[1].err = 1'b1;
    send(3'd3, 4'b0000, rnd128(), rnd128(), 16'hFFFF);

    // no response at all -> timeout
    default_plan();
    pl[0].delay = 200;
    send(3'd1, 4'b0000, rnd128(), rnd128(), 16'hFFFF);

    // response on the timeout cycle wins
    default_plan();
    pl[0].delay = TMO;
    send(3'd1, 4'b0000, rnd128(), rnd128(), 16'hFFFF);

    // empty bundle and oversized count
    default_plan();
    send(3'd0, 4'b1111, rnd128(), rnd128(), 16'hFFFF);
    default_plan();
    send(3'd7, 4'($urandom), rnd128(), rnd128(), 16'($urandom));

    // randomized bundles
    for (int k = 0; k < 150; k++) begin
      rand_plan();
      send(3'($urandom_range(0, 7)), 4'($urandom), rnd128(), rnd128(), 16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // reset while txn1 waits, followed by a late response
    default_plan();
    pl[1].delay = 200;
    a = rnd128();
    send(3'd2, 4'b0000, a, rnd128(), 16'hFFFF);
    @(posedge clk); #1;
    #1 hold = 1'b1;
    @(posedge clk); #1;
    chk("rst_test_issue1", {bus.mem_cen, bus.mem_addr}, {1'b1, a[63:32]});
    @(posedge clk); #1;
    chk("rst_test_wait1", bus.mem_cen, 1'b0);
    rst = 1'b1;
    exp_q.delete(exp_q.size() - 1);
    plan_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_mem", {bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_ben}, '0);
    chk("rst_mid_rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_done, bus.rsp_rdata}, '0);
    chk("rst_mid_ready", bus.req_ready, 1'b1);
    m_valid = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    chk("late_rsp_ignored", {bus.rsp_valid, bus.rsp_error, bus.rsp_done, bus.rsp_rdata}, '0);
    chk("late_rsp_ready", bus.req_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    hold = 1'b0;

    // recovery after reset
    default_plan();
    send(3'd2, 4'b0010, rnd128(), rnd128(), 16'hFFFF);

    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_expected", exp_q.size(), 0);
    chk("drain_plans", plan_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
